agu_context_sequencer: RTL and testbench

//  Loads AGU context words into the AGU context cache, then steps the context pointer through

---
 rtl/agu_seq_pkg.sv | 17 +
 rtl/agu_loop_counter.sv | 34 +++
 rtl/agu_context_sequencer.sv | 167 ++++++++++++++++
 tb/tb_agu_context_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/agu_seq_pkg.sv
// Shared constants and FSM state encoding for the AGU context sequencer.
package agu_seq_pkg;

  localparam int AGU_CTX_W  = 29;
  localparam int AGU_DEPTH  = 16;
  localparam int AGU_AW     = $clog2(AGU_DEPTH);
  localparam int AGU_CP_W   = 16;
  localparam int AGU_LOOP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/agu_loop_counter.sv
// Iteration counter: loads max(load_val,1), counts down without wrapping,
// and flags the final iteration.
module agu_loop_counter
  import agu_seq_pkg::*;
#(
  parameter int LOOP_W = AGU_LOOP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LOOP_W-1:0] load_val,
  input  logic              dec_en,
  output logic              is_last
);

  logic [LOOP_W-1:0] iter_d, iter_q;

  always_comb begin
    iter_d = iter_q;
    if (load_en) begin
      iter_d = (load_val == '0) ? LOOP_W'(1) : load_val;
    end else if (dec_en && (iter_q != '0)) begin
      iter_d = iter_q - LOOP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) iter_q <= '0;
    else     iter_q <= iter_d;
  end

  assign is_last = (iter_q == LOOP_W'(1));

endmodule

// File: rtl/agu_context_sequencer.sv
// Loads AGU context words into the context cache, then steps the context
// pointer through them for a programmed number of loop iterations.
module agu_context_sequencer
  import agu_seq_pkg::*;
#(
  parameter int CTX_W  = AGU_CTX_W,
  parameter int DEPTH  = AGU_DEPTH,
  parameter int AW     = AGU_AW,
  parameter int CP_W   = AGU_CP_W,
  parameter int LOOP_W = AGU_LOOP_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CTX_W-1:0]  cfg_data,
  input  logic              cfg_last,
  input  logic              start,
  input  logic [LOOP_W-1:0] loop_count,
  input  logic              stall,
  output logic              cc_we,
  output logic [AW-1:0]     cc_waddr,
  output logic [CTX_W-1:0]  cc_wdata,
  output logic [CP_W-1:0]   CP,
  output logic              exec_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_e       state_d, state_q;
  logic [AW-1:0]    cp_d, cp_q;
  logic [AW-1:0]    wp_d, wp_q;
  logic [AW:0]      num_ctx_d, num_ctx_q;
  logic             loaded_d, loaded_q;
  logic             cc_we_d, cc_we_q;
  logic [AW-1:0]    cc_waddr_d, cc_waddr_q;
  logic [CTX_W-1:0] cc_wdata_d, cc_wdata_q;
  logic             err_d, err_q;
  logic             cfg_hs;
  logic             at_last_ctx;
  logic             iter_load, iter_dec, iter_is_last;

  assign cfg_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign cfg_hs      = cfg_valid && cfg_ready;
  assign at_last_ctx = ({1'b0, cp_q} == (num_ctx_q - (AW+1)'(1)));

  always_comb begin
    state_d    = state_q;
    cp_d       = cp_q;
    wp_d       = wp_q;
    num_ctx_d  = num_ctx_q;
    loaded_d   = loaded_q;
    cc_we_d    = 1'b0;
    cc_waddr_d = cc_waddr_q;
    cc_wdata_d = cc_wdata_q;
    err_d      = 1'b0;
    iter_load  = 1'b0;
    iter_dec   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A configuration word takes priority; a coincident start is dropped.
        if (cfg_hs) begin
          cc_we_d    = 1'b1;
          cc_waddr_d = '0;
          cc_wdata_d = cfg_data;
          if (cfg_last) begin
            num_ctx_d = (AW+1)'(1);
            loaded_d  = 1'b1;
            wp_d      = '0;
          end else begin
            loaded_d = 1'b0;
            wp_d     = AW'(1);
            state_d  = ST_LOAD;
          end
        end else if (start) begin
          if (loaded_q) begin
            iter_load = 1'b1;
            cp_d      = '0;
            state_d   = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (cfg_hs) begin
          cc_we_d    = 1'b1;
          cc_waddr_d = wp_q;
          cc_wdata_d = cfg_data;
          wp_d       = wp_q + AW'(1);
          // A full cache closes the load; any further words start a new one.
          if (cfg_last || (wp_q == AW'(DEPTH-1))) begin
            num_ctx_d = {1'b0, wp_q} + (AW+1)'(1);
            loaded_d  = 1'b1;
            wp_d      = '0;
            state_d   = ST_IDLE;
            err_d     = !cfg_last;
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (at_last_ctx) begin
            cp_d     = '0;
            iter_dec = 1'b1;
            if (iter_is_last) state_d = ST_DONE;
          end else begin
            cp_d = cp_q + AW'(1);
          end
        end
      end
      ST_DONE: begin
        cp_d    = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cp_q      <= '0;
      wp_q      <= '0;
      num_ctx_q <= '0;
      loaded_q  <= 1'b0;
      cc_we_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cp_q      <= cp_d;
      wp_q      <= wp_d;
      num_ctx_q <= num_ctx_d;
      loaded_q  <= loaded_d;
      cc_we_q   <= cc_we_d;
      err_q     <= err_d;
    end
  end

  // Write address/data only qualify cc_we, so they carry no reset.
  always_ff @(posedge CLK) begin
    cc_waddr_q <= cc_waddr_d;
    cc_wdata_q <= cc_wdata_d;
  end

  agu_loop_counter #(
    .LOOP_W (LOOP_W)
  ) u_loop_counter (
    .clk      (CLK),
    .rst      (RST),
    .load_en  (iter_load),
    .load_val (loop_count),
    .dec_en   (iter_dec),
    .is_last  (iter_is_last)
  );

  assign cc_we      = cc_we_q;
  assign cc_waddr   = cc_waddr_q;
  assign cc_wdata   = cc_wdata_q;
  assign CP         = {{(CP_W-AW){1'b0}}, cp_q};
  assign exec_valid = (state_q == ST_RUN) && !stall;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_agu_context_sequencer.sv
// Directed scoreboard bench for agu_context_sequencer: expected cache writes
// and context pointers are queued when stimulus is driven and popped on output.
module tb_agu_context_sequencer;

  logic        clk;
  logic        RST;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [28:0] cfg_data;
  logic        cfg_last;
  logic        start;
  logic [15:0] loop_count;
  logic        stall;
  logic        cc_we;
  logic [3:0]  cc_waddr;
  logic [28:0] cc_wdata;
  logic [15:0] CP;
  logic        exec_valid;
  logic        busy;
  logic        done;
  logic        err;

  agu_context_sequencer dut (
    .CLK        (clk),
    .RST        (RST),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .start      (start),
    .loop_count (loop_count),
    .stall      (stall),
    .cc_we      (cc_we),
    .cc_waddr   (cc_waddr),
    .cc_wdata   (cc_wdata),
    .CP         (CP),
    .exec_valid (exec_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  int          err_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_exec_cyc = 0;
  int          e0, d0;
  logic [32:0] wr_exp[$];
  logic [15:0] cp_exp[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle at the falling edge, then let the rising edge consume inputs.
  task automatic tick();
    logic [32:0] w;
    logic [15:0] c;
    @(negedge clk);
    cyc++;
    if (cc_we) begin
      chk("cc_we_expected", 64'(wr_exp.size() != 0), 64'd1);
      if (wr_exp.size() != 0) begin
        w = wr_exp.pop_front();
        chk("cc_write", 64'({cc_waddr, cc_wdata}), 64'(w));
      end
    end
    if (exec_valid) begin
      last_exec_cyc = cyc;
      chk("exec_expected", 64'(cp_exp.size() != 0), 64'd1);
      if (cp_exp.size() != 0) begin
        c = cp_exp.pop_front();
        chk("cp_seq", 64'(CP), 64'(c));
      end
    end
    if (err) err_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [3:0] addr, input logic [28:0] data, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = data;
    cfg_last  = last;
    wr_exp.push_back({addr, data});
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] lc);
    start      = 1'b1;
    loop_count = lc;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int d_start;
    d_start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d_start) break;
      tick();
    end
    chk("done_within_budget", 64'(done_cnt - d_start), 64'd1);
  endtask

  initial begin
    RST = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    start = 1'b0; loop_count = '0; stall = 1'b0;
    tick(); tick();
    chk("rst_cp", 64'(CP), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cc_we", 64'(cc_we), 64'd0);
    chk("rst_err_done_exec", 64'({err, done, exec_valid}), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    RST = 1'b0;
    tick();

    // Start with nothing loaded
    e0 = err_cnt;
    start_run(16'd3);
    tick(); tick();
    chk("start_unloaded_err", 64'(err_cnt - e0), 64'd1);
    chk("start_unloaded_busy", 64'(busy), 64'd0);

    // Three words, two iterations
    send_word(4'd0, 29'(32'h0AAA_0001), 1'b0);
    send_word(4'd1, 29'(32'h1555_0002), 1'b0);
    send_word(4'd2, 29'(32'h0F0F_0003), 1'b1);
    tick();
    chk("load3_writes_drained", 64'(wr_exp.size()), 64'd0);
    for (int i = 0; i < 6; i++) cp_exp.push_back(16'(i % 3));
    d0 = done_cnt;
    start_run(16'd2);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_cfg_ready", 64'(cfg_ready), 64'd0);
    run_until_done(30);
    chk("run3x2_cp_drained", 64'(cp_exp.size()), 64'd0);
    chk("run3x2_done_latency", 64'(done_cyc - last_exec_cyc), 64'd1);
    tick();
    chk("run3x2_done_once", 64'(done_cnt - d0), 64'd1);
    chk("run3x2_idle", 64'(busy), 64'd0);

    // One word, loop_count 0 behaves as one iteration
    send_word(4'd0, 29'($urandom), 1'b1);
    tick();
    cp_exp.push_back(16'd0);
    start_run(16'd0);
    run_until_done(10);
    chk("lc0_busy_drop", 64'(busy), 64'd0);
    chk("lc0_done_latency", 64'(done_cyc - last_exec_cyc), 64'd1);
    chk("lc0_cp_drained", 64'(cp_exp.size()), 64'd0);

    // Stall for four cycles while CP==1
    send_word(4'd0, 29'($urandom), 1'b0);
    send_word(4'd1, 29'($urandom), 1'b0);
    send_word(4'd2, 29'($urandom), 1'b1);
    tick();
    for (int i = 0; i < 6; i++) cp_exp.push_back(16'(i % 3));
    start_run(16'd2);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_cp_hold", 64'(CP), 64'd1);
      chk("stall_no_exec", 64'(exec_valid), 64'd0);
    end
    stall = 1'b0;
    run_until_done(30);
    chk("stall_cp_drained", 64'(cp_exp.size()), 64'd0);
    tick();

    // Sixteen words without last overflow the cache
    e0 = err_cnt;
    for (int i = 0; i < 15; i++) send_word(4'(i), 29'($urandom), 1'b0);
    tick();
    chk("ovf_no_early_err", 64'(err_cnt - e0), 64'd0);
    send_word(4'd15, 29'($urandom), 1'b0);
    tick();
    chk("ovf_err_at_16", 64'(err_cnt - e0), 64'd1);
    chk("ovf_back_idle", 64'(busy), 64'd0);
    for (int i = 0; i < 16; i++) cp_exp.push_back(16'(i));
    start_run(16'd1);
    run_until_done(40);
    chk("ovf_num_ctx16", 64'(cp_exp.size()), 64'd0);
    tick();
    send_word(4'd0, 29'($urandom), 1'b0);
    send_word(4'd1, 29'($urandom), 1'b1);
    tick();
    chk("ovf_next_load_no_err", 64'(err_cnt - e0), 64'd1);
    chk("ovf_next_load_writes", 64'(wr_exp.size()), 64'd0);

    // Word and start together: write wins, start dropped silently
    e0 = err_cnt;
    cfg_valid = 1'b1; cfg_data = 29'h0123_4567; cfg_last = 1'b1;
    start = 1'b1; loop_count = 16'd1;
    wr_exp.push_back({4'd0, 29'h0123_4567});
    tick();
    cfg_valid = 1'b0; cfg_last = 1'b0; start = 1'b0;
    chk("simul_no_run", 64'(busy), 64'd0);
    tick(); tick();
    chk("simul_no_err", 64'(err_cnt - e0), 64'd0);
    chk("simul_write_done", 64'(wr_exp.size()), 64'd0);

    // Reset mid-run at CP==2
    send_word(4'd0, 29'($urandom), 1'b0);
    send_word(4'd1, 29'($urandom), 1'b0);
    send_word(4'd2, 29'($urandom), 1'b1);
    tick();
    cp_exp.push_back(16'd0); cp_exp.push_back(16'd1); cp_exp.push_back(16'd2);
    start_run(16'd2);
    tick(); tick();
    chk("pre_rst_cp", 64'(CP), 64'd2);
    d0 = done_cnt;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_run_cp", 64'(CP), 64'd0);
    chk("rst_run_busy", 64'(busy), 64'd0);
    tick(); tick();
    chk("rst_run_no_done", 64'(done_cnt - d0), 64'd0);
    e0 = err_cnt;
    start_run(16'd1);
    tick();
    chk("rst_cleared_loaded", 64'(err_cnt - e0), 64'd1);
    chk("rst_restart_idle", 64'(busy), 64'd0);

    chk("final_wr_queue", 64'(wr_exp.size()), 64'd0);
    chk("final_cp_queue", 64'(cp_exp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
